// File: rtl/multi_pipe_mul_param.sv
// Pipelined shift-and-add multiplier with a binary adder tree, optional signed
// mode (sign-magnitude internally) and a valid/ready handshake with global stall.
module multi_pipe_mul_param #(
   parameter int WIDTH     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mul_en_in,
   output logic                 mul_rdy_in,
   input  logic [WIDTH-1:0]     mul_a,
   input  logic [WIDTH-1:0]     mul_b,
   input  logic                 mul_signed,
   output logic                 mul_en_out,
   input  logic                 mul_rdy_out,
   output logic [2*WIDTH-1:0]   mul_out
);

   localparam int S  = $clog2(WIDTH);
   localparam int PW = 2 * WIDTH;

   logic             adv;
   logic             init_q;
   logic             take;
   logic             sgn_mode;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] mag_a_d;
   logic [WIDTH-1:0] mag_b_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [S:0]       vld_q;
   logic [S:0]       neg_q;
   logic [PW-1:0]    pp    [WIDTH];
   logic [PW-1:0]    node_q[1:WIDTH-1];
   logic [PW-1:0]    lft   [1:WIDTH-1];
   logic [PW-1:0]    rgt   [1:WIDTH-1];
   logic [PW-1:0]    res_d;

   // The whole pipe moves as one; it only stops when the output is full and unread.
   assign adv        = mul_rdy_out | ~mul_en_out;
   assign mul_rdy_in = adv & init_q;
   assign take       = mul_en_in & mul_rdy_in;

   assign sgn_mode = mul_signed & SIGNED_EN;
   assign sign_a   = sgn_mode & mul_a[WIDTH-1];
   assign sign_b   = sgn_mode & mul_b[WIDTH-1];
   assign mag_a_d  = sign_a ? -mul_a : mul_a;
   assign mag_b_d  = sign_b ? -mul_b : mul_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q <= 1'b0;
      end else begin
         init_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         vld_q <= '0;
         neg_q <= '0;
      end else if (adv) begin
         a_q   <= take ? mag_a_d : '0;
         b_q   <= take ? mag_b_d : '0;
         vld_q <= {vld_q[S-1:0], take};
         neg_q <= {neg_q[S-1:0], take & (sign_a ^ sign_b)};
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
         assign pp[gi] = b_q[gi] ? (PW'(a_q) << gi) : '0;
      end

      // Heap-indexed tree: node i sums children 2i and 2i+1; leaves are the partial products.
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_node
         if (2 * gi >= WIDTH) begin : g_leaf
            assign lft[gi] = pp[2*gi-WIDTH];
            assign rgt[gi] = pp[2*gi+1-WIDTH];
         end else begin : g_inner
            assign lft[gi] = node_q[2*gi];
            assign rgt[gi] = node_q[2*gi+1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               node_q[gi] <= '0;
            end else if (adv) begin
               node_q[gi] <= lft[gi] + rgt[gi];
            end
         end
      end
   endgenerate

   always_comb begin
      res_d = '0;
      if (vld_q[S]) begin
         res_d = neg_q[S] ? -node_q[1] : node_q[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_en_out <= 1'b0;
         mul_out    <= '0;
      end else if (adv) begin
         mul_en_out <= vld_q[S];
         mul_out    <= res_d;
      end
   end

endmodule

// File: tb/tb_multi_pipe_mul_param.sv
// Scoreboard bench for the pipelined multiplier: an 8-bit signed-capable instance
// and a 16-bit unsigned-only instance sharing clock and reset.
module tb_multi_pipe_mul_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mul_en_in, mul_rdy_in, mul_signed, mul_en_out, mul_rdy_out;
   logic [7:0]  mul_a, mul_b;
   logic [15:0] mul_out;

   logic        en_in2, rdy_in2, sgn2, en_out2, rdy_out2;
   logic [15:0] a2, b2;
   logic [31:0] out2;

   typedef struct {
      logic [15:0] prod;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;
   bit          mon_on = 1'b0;
   bit          lat_mode = 1'b0;
   bit          prev_stall = 1'b0;
   logic        prev_en;
   logic [15:0] prev_out;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multi_pipe_mul_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .mul_en_in(mul_en_in), .mul_rdy_in(mul_rdy_in),
      .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed), .mul_en_out(mul_en_out),
      .mul_rdy_out(mul_rdy_out), .mul_out(mul_out)
   );

   multi_pipe_mul_param #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
      .clk(clk), .rst_n(rst_n), .mul_en_in(en_in2), .mul_rdy_in(rdy_in2),
      .mul_a(a2), .mul_b(b2), .mul_signed(sgn2), .mul_en_out(en_out2),
      .mul_rdy_out(rdy_out2), .mul_out(out2)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
      longint pa, pb;
      pa = s ? longint'($signed(a)) : longint'(a);
      pb = s ? longint'($signed(b)) : longint'(b);
      return 16'(pa * pb);
   endfunction

   // Caller is always positioned just after a rising edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
      mul_a = a; mul_b = b; mul_signed = s; mul_en_in = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (mul_rdy_in) break;
      end
      if (!mul_rdy_in) check("send_ready", mul_rdy_in, 1);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      mul_en_in = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Monitor: pushes on accept, pops on output handshake, checks hold and zeroing rules.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_on && rst_n) begin
            if (mul_en_in && mul_rdy_in)
               sb.push_back('{model(mul_a, mul_b, mul_signed), cyc, lat_mode});
            if (prev_stall) begin
               check("stall_hold_vld", mul_en_out, prev_en);
               check("stall_hold_out", mul_out, prev_out);
            end
            if (!mul_en_out) begin
               check("idle_zero", mul_out, 0);
            end else if (!mul_rdy_out) begin
               check("stall_rdy_in", mul_rdy_in, 0);
            end else if (sb.size() == 0) begin
               check("unexpected_out", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               $display("out cycle %0d: mul_out=0x%04h expected 0x%04h", cyc, mul_out, e.prod);
               check("product", mul_out, e.prod);
               if (e.lat) check("latency", cyc - e.acc, 5);
            end
            prev_stall = mul_en_out && !mul_rdy_out;
            prev_en    = mul_en_out;
            prev_out   = mul_out;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst_n = 1'b0; mul_en_in = 1'b0; mul_a = '0; mul_b = '0; mul_signed = 1'b0; mul_rdy_out = 1'b1;
      en_in2 = 1'b0; a2 = '0; b2 = '0; sgn2 = 1'b0; rdy_out2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_en_out", mul_en_out, 0);
      check("rst_out", mul_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rdy_after_rst", mul_rdy_in, 1);
      mon_on = 1'b1;

      // T1: unsigned extreme with fixed latency
      lat_mode = 1'b1;
      send(8'hFF, 8'hFF, 1'b0);
      idle(8);

      // T2: signed corner cases back-to-back
      send(8'h80, 8'h80, 1'b1);
      send(8'hFF, 8'h7F, 1'b1);
      send(8'h00, 8'hFB, 1'b1);
      idle(8);

      // T4: bubble in the input stream
      send(8'd3, 8'd5, 1'b0);
      idle(1);
      send(8'h07, 8'hF7, 1'b1);
      idle(8);

      // T3: random mixed stream with a 3-cycle downstream stall
      lat_mode = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++)
               send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            mul_en_in = 1'b0;
         end
         begin
            repeat (8) @(posedge clk);
            #1 mul_rdy_out = 1'b0;
            repeat (3) @(posedge clk);
            #1 mul_rdy_out = 1'b1;
         end
      join
      idle(30);
      check("t3_drain", sb.size(), 0);

      // T5: reset with operations in flight
      lat_mode = 1'b1;
      send(8'd11, 8'd13, 1'b0);
      send(8'hF0, 8'd3, 1'b1);
      send(8'd200, 8'd2, 1'b0);
      idle(1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_vld", mul_en_out, 0);
      check("t5_rst_out", mul_out, 0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(10);
      send(8'h12, 8'h34, 1'b0);
      idle(8);
      check("t5_drain", sb.size(), 0);

      // T6: 16-bit unsigned-only instance ignores mul_signed
      a2 = 16'hFFFF; b2 = 16'hFFFF; sgn2 = 1'b1; en_in2 = 1'b1;
      @(negedge clk);
      c0 = cyc;
      check("t6_rdy_in", rdy_in2, 1);
      @(posedge clk); #1;
      en_in2 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (en_out2) break;
      end
      $display("t6 cycle %0d: mul_out=0x%08h", cyc, out2);
      check("t6_valid", en_out2, 1);
      check("t6_latency", cyc - c0, 6);
      check("t6_product", out2, 32'hFFFE0001);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
